mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameters: none; all widths fixed (32-bit data/address, 5-bit register index).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 MemtoReg_i  in  2; Jump_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, zero_flag_i  in  1 each: control fields held by the upstream EX/MEM register.
REQ-005 PC_beq_i, alu_result_i, ReadData2_i, inst_i  in  32 each; WriteRegister_i  in  5: data fields from the EX/MEM register.
REQ-006 dmem_req, dmem_we  out  1; dmem_addr, dmem_wdata  out  32: data-memory request (registered).
REQ-007 dmem_ack  in  1; dmem_rdata  in  32: memory completion and load data, valid in the ack cycle.
REQ-008 stall_o  out  1: freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-009 PCSrc_o  out  1; PC_beq_o  out  32: branch redirect and target (combinational).
REQ-010 MemtoReg_o  out  2; RegWrite_o  out  1; ReadData_o, alu_result_o, inst_o  out  32; WriteRegister_o  out  5: MEM/WB register.
REQ-011 misalign_o  out  1: misaligned-access flag (see Configuration).

Function
REQ-012 FSM states SHALL be IDLE, BUSY and DONE.
REQ-013 A memory op SHALL be MemRead_i|MemWrite_i; if both are set, it SHALL be treated as a write.
REQ-014 IDLE with no memory op: no stall; the MEM/WB register SHALL load the inputs at the next edge (1-cycle latency), with ReadData_o loaded as 0.
REQ-015 IDLE with a memory op: stall_o=1 combinationally, go to BUSY, and register dmem_req=1, dmem_we=MemWrite_i, dmem_addr=alu_result_i, dmem_wdata=ReadData2_i.
REQ-016 BUSY: stall_o=1; request fields held stable until dmem_ack=1.
REQ-017 On dmem_ack in BUSY: capture dmem_rdata (loads only), drop dmem_req, go to DONE.
REQ-018 DONE: stall_o=0; the MEM/WB register SHALL load the held inputs plus captured ReadData at the next edge; then return to IDLE.
REQ-019 Minimum memory-op latency SHALL be 3 cycles (detect, ack, DONE); each extra ack wait cycle SHALL add 1.
REQ-020 Each cycle stall_o=1, the MEM/WB register SHALL load a bubble: all outputs 0, so RegWrite_o=0.
REQ-021 dmem_ack outside BUSY SHALL be ignored.
REQ-022 PCSrc_o SHALL be Branch_i & zero_flag_i & ~stall_o; PC_beq_o SHALL be PC_beq_i.
REQ-023 Jump_i SHALL have no effect in this stage (resolved upstream).

Reset
REQ-024 While reset=0: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, misalign_o and all MEM/WB outputs SHALL be 0, asynchronously.
REQ-025 Reset in BUSY SHALL abort the access: dmem_req drops immediately and the captured data is discarded.
REQ-026 The first edge after reset release SHALL evaluate the inputs from IDLE.

Configuration
REQ-027 With MEM_MISALIGN_TRAP_EN defined, a memory op with alu_result_i[1:0]!=0 SHALL:
- issue no request and not stall;
- load a MEM/WB bubble;
- set misalign_o=1 for exactly one cycle (registered).
REQ-028 Without MEM_MISALIGN_TRAP_EN:
- dmem_addr[1:0] SHALL be forced to 00 and the access SHALL proceed normally;
- misalign_o SHALL be tied 0.

Verification
REQ-029 ALU op RegWrite_i=1, alu_result_i=0x0000_0010, WriteRegister_i=8 -> next edge: alu_result_o=0x10, WriteRegister_o=8, RegWrite_o=1, stall_o never high.
REQ-030 Load, alu_result_i=0x100, dmem_ack one cycle after req, dmem_rdata=0xDEAD_BEEF -> stall_o high 2 cycles, dmem_we=0; then ReadData_o=0xDEADBEEF, MemtoReg_o=01.
REQ-031 Store, alu_result_i=0x200, ReadData2_i=0x1234_5678, ack after 3 wait cycles -> dmem_addr=0x200, dmem_wdata=0x12345678, dmem_we=1 held; stall_o high 5 cycles; RegWrite_o=0 after.
REQ-032 Branch_i=1, zero_flag_i=1, PC_beq_i=0x40 -> PCSrc_o=1, PC_beq_o=0x40; the same inputs during a stall -> PCSrc_o=0.
REQ-033 reset=0 asserted mid-BUSY -> dmem_req=0 and all outputs 0 within the same cycle; a later spurious dmem_ack is ignored.
REQ-034 With MEM_MISALIGN_TRAP_EN, load at 0x102 -> no dmem_req, misalign_o=1 for 1 cycle, RegWrite_o=0; without the macro -> dmem_addr=0x100.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage with a registered data-memory handshake.
//
// Sits between the EX/MEM register (inputs *_i) and the MEM/WB register
// (outputs *_o, held in this module). Loads and stores are issued to an external
// data memory through a req/ack handshake. The pipeline is frozen (stall_o)
// until the access completes.
//
// Ports
//   clk, reset             clock (rising edge), asynchronous active-low reset
//   MemtoReg_i, Jump_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i,
//   zero_flag_i            control fields from EX/MEM (Jump_i is unused here)
//   PC_beq_i, alu_result_i, ReadData2_i, inst_i, WriteRegister_i
//                          data fields from EX/MEM
//   dmem_req, dmem_we, dmem_addr, dmem_wdata
//                          registered data-memory request
//   dmem_ack, dmem_rdata   memory completion and load data (ack cycle)
//   stall_o                freezes PC, IF/ID, ID/EX and EX/MEM
//   PCSrc_o, PC_beq_o      branch redirect and target (combinational)
//   MemtoReg_o, RegWrite_o, ReadData_o, alu_result_o, inst_o,
//   WriteRegister_o        MEM/WB register
//   misalign_o             one-cycle misaligned-access flag
//
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   defined   : a misaligned memory op is dropped, a bubble is written back
//               and misalign_o pulses for one cycle.
//   undefined : dmem_addr[1:0] is forced to 00, the access proceeds and
//               misalign_o is tied 0.
// -----------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  // EX/MEM control
  input  logic [1:0]  MemtoReg_i,
  input  logic        Jump_i,
  input  logic        Branch_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic        zero_flag_i,
  // EX/MEM data
  input  logic [31:0] PC_beq_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] ReadData2_i,
  input  logic [31:0] inst_i,
  input  logic [4:0]  WriteRegister_i,
  // data memory
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  // pipeline control
  output logic        stall_o,
  output logic        PCSrc_o,
  output logic [31:0] PC_beq_o,
  // MEM/WB register
  output logic [1:0]  MemtoReg_o,
  output logic        RegWrite_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] inst_o,
  output logic [4:0]  WriteRegister_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [31:0] rdata_q;   // load data captured in the ack cycle
  logic        mem_op;
  logic        trap;

  // Jumps are resolved upstream; the field only travels through the pipe.
  logic unused_jump;
  assign unused_jump = Jump_i;

  // A set MemWrite_i wins over MemRead_i, so both set is a write.
  assign mem_op = MemRead_i | MemWrite_i;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap       = mem_op & (alu_result_i[1:0] != 2'b00);
  assign misalign_o = misalign_q;
`else
  assign trap       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Stall in the detect cycle and for every cycle spent waiting for ack.
  // Gated by reset so a held memory op cannot freeze a pipeline being reset.
  assign stall_o  = reset & (((state == IDLE) & mem_op & ~trap) | (state == BUSY));
  assign PCSrc_o  = Branch_i & zero_flag_i & ~stall_o;
  assign PC_beq_o = PC_beq_i;

  // NOTE: every register here is sequential state, so all assignments are
  // non-blocking; blocking assignments would let later statements observe
  // same-edge updates and break the register semantics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      rdata_q         <= '0;
      MemtoReg_o      <= '0;
      RegWrite_o      <= 1'b0;
      ReadData_o      <= '0;
      alu_result_o    <= '0;
      inst_o          <= '0;
      WriteRegister_o <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q      <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= trap & (state == IDLE);
`endif
      unique case (state)
        IDLE: begin
          if (mem_op && !trap) begin
            state      <= BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_i;
            dmem_wdata <= ReadData2_i;
            rdata_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            dmem_addr  <= alu_result_i;
`else
            dmem_addr  <= {alu_result_i[31:2], 2'b00};
`endif
          end
          if (mem_op) begin
            // Either the detect cycle of an access (stalling) or a trapped
            // misaligned op: write back a bubble.
            MemtoReg_o      <= '0;
            RegWrite_o      <= 1'b0;
            ReadData_o      <= '0;
            alu_result_o    <= '0;
            inst_o          <= '0;
            WriteRegister_o <= '0;
          end else begin
            MemtoReg_o      <= MemtoReg_i;
            RegWrite_o      <= RegWrite_i;
            ReadData_o      <= '0;
            alu_result_o    <= alu_result_i;
            inst_o          <= inst_i;
            WriteRegister_o <= WriteRegister_i;
          end
        end

        BUSY: begin
          MemtoReg_o      <= '0;
          RegWrite_o      <= 1'b0;
          ReadData_o      <= '0;
          alu_result_o    <= '0;
          inst_o          <= '0;
          WriteRegister_o <= '0;
          if (dmem_ack) begin
            state      <= DONE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rdata_q    <= dmem_we ? 32'h0 : dmem_rdata;
          end
        end

        DONE: begin
          // Upstream was frozen, so the inputs are still those of the access.
          state           <= IDLE;
          MemtoReg_o      <= MemtoReg_i;
          RegWrite_o      <= RegWrite_i;
          ReadData_o      <= rdata_q;
          alu_result_o    <= alu_result_i;
          inst_o          <= inst_i;
          WriteRegister_o <= WriteRegister_i;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Expected MEM/WB contents are pushed to a scoreboard queue when an
// instruction is driven and popped when its write-back edge has passed.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [1:0]  MemtoReg_i;
  logic        Jump_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, zero_flag_i;
  logic [31:0] PC_beq_i, alu_result_i, ReadData2_i, inst_i;
  logic [4:0]  WriteRegister_i;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_o, PCSrc_o;
  logic [31:0] PC_beq_o;
  logic [1:0]  MemtoReg_o;
  logic        RegWrite_o;
  logic [31:0] ReadData_o, alu_result_o, inst_o;
  logic [4:0]  WriteRegister_o;
  logic        misalign_o;

  typedef struct packed {
    logic [1:0]  m2r;
    logic        rw;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] inst;
    logic [4:0]  wr;
  } wb_t;

  wb_t wb_act;
  assign wb_act = {MemtoReg_o, RegWrite_o, ReadData_o, alu_result_o, inst_o, WriteRegister_o};

  wb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .MemtoReg_i(MemtoReg_i), .Jump_i(Jump_i), .Branch_i(Branch_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
    .zero_flag_i(zero_flag_i),
    .PC_beq_i(PC_beq_i), .alu_result_i(alu_result_i), .ReadData2_i(ReadData2_i),
    .inst_i(inst_i), .WriteRegister_i(WriteRegister_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_o(stall_o), .PCSrc_o(PCSrc_o), .PC_beq_o(PC_beq_o),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .ReadData_o(ReadData_o),
    .alu_result_o(alu_result_o), .inst_o(inst_o), .WriteRegister_o(WriteRegister_o),
    .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemtoReg_i = 2'b00; Jump_i = 1'b0; Branch_i = 1'b0; MemRead_i = 1'b0;
    MemWrite_i = 1'b0; RegWrite_i = 1'b0; zero_flag_i = 1'b0;
    PC_beq_i = '0; alu_result_i = '0; ReadData2_i = '0; inst_i = '0;
    WriteRegister_i = '0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    MemRead_i = 1'b1; alu_result_i = 32'h0000_0040;
    #3;
    step();
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, misalign_o, stall_o} !== '0 || wb_act !== '0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h mis=%b stall=%b wb=%h required all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, misalign_o, stall_o, wb_act);
    end
    idle_inputs();
    step();
    reset = 1'b1;
  endtask

  // ALU op: one-cycle pass-through, never stalls.
  task automatic test_alu_op(input logic [31:0] alu, input logic [4:0] wreg, input logic [31:0] inst);
    wb_t exp;
    MemtoReg_i = 2'b00; RegWrite_i = 1'b1; alu_result_i = alu;
    WriteRegister_i = wreg; inst_i = inst; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    sb.push_back('{2'b00, 1'b1, 32'h0, alu, inst, wreg});
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_no_stall: stall_o=%b required 0", stall_o);
    end
    step();
    exp = sb.pop_front();
    n_checks++;
    if (wb_act !== exp || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_writeback: wb=%h stall=%b required wb=%h stall=0", wb_act, stall_o, exp);
    end
    idle_inputs();
  endtask

  // Full load/store handshake with `waits` ack-less BUSY cycles.
  task automatic run_mem_op(input string name, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int waits, input logic [31:0] exp_addr);
    wb_t exp;
    int  stalls = 0;
    logic [4:0]  wreg = wr ? 5'd0 : 5'd9;
    logic [31:0] inst = wr ? 32'h00A0_2023 : 32'h0000_2483;
    MemRead_i = !wr; MemWrite_i = wr; RegWrite_i = !wr;
    MemtoReg_i = wr ? 2'b00 : 2'b01;
    alu_result_i = addr; ReadData2_i = wdata; inst_i = inst; WriteRegister_i = wreg;
    sb.push_back('{wr ? 2'b00 : 2'b01, !wr, wr ? 32'h0 : rdata, addr, inst, wreg});
    #1;
    if (stall_o) stalls++;
    n_checks++;
    if (PCSrc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pcsrc_stall: PCSrc_o=%b required 0", name, PCSrc_o);
    end
    step();
    n_checks++;
    if (dmem_req !== 1'b1 || dmem_we !== wr || dmem_addr !== exp_addr || dmem_wdata !== (wr ? wdata : 32'h0 | wdata)) begin
      n_fail++;
      $display("FAIL %s_request: req=%b we=%b addr=%h wdata=%h required req=1 we=%b addr=%h wdata=%h",
               name, dmem_req, dmem_we, dmem_addr, dmem_wdata, wr, exp_addr, wdata);
    end
    for (int i = 0; i < waits; i++) begin
      if (stall_o) stalls++;
      n_checks++;
      if (wb_act !== '0) begin
        n_fail++;
        $display("FAIL %s_bubble: wb=%h required 0", name, wb_act);
      end
      step();
      n_checks++;
      if (dmem_req !== 1'b1 || dmem_we !== wr || dmem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL %s_hold: req=%b we=%b addr=%h required req=1 we=%b addr=%h",
                 name, dmem_req, dmem_we, dmem_addr, wr, exp_addr);
      end
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    #1;
    if (stall_o) stalls++;
    step();
    dmem_ack = 1'b0; dmem_rdata = 32'hBAD0_0BAD;
    n_checks++;
    if (dmem_req !== 1'b0 || stall_o !== 1'b0 || wb_act !== '0 ||
        PCSrc_o !== (Branch_i & zero_flag_i)) begin
      n_fail++;
      $display("FAIL %s_done: req=%b stall=%b wb=%h pcsrc=%b required req=0 stall=0 wb=0 pcsrc=%b",
               name, dmem_req, stall_o, wb_act, PCSrc_o, Branch_i & zero_flag_i);
    end
    step();
    exp = sb.pop_front();
    n_checks++;
    if (wb_act !== exp) begin
      n_fail++;
      $display("FAIL %s_writeback: wb=%h required %h", name, wb_act, exp);
    end
    n_checks++;
    if (stalls != waits + 2) begin
      n_fail++;
      $display("FAIL %s_stall_cycles: %0d required %0d", name, stalls, waits + 2);
    end
    idle_inputs();
  endtask

  task automatic test_load();
    run_mem_op("load", 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 32'h0000_0100);
  endtask

  task automatic test_store();
    run_mem_op("store", 1'b1, 32'h0000_0200, 32'h1234_5678, 32'h5555_AAAA, 3, 32'h0000_0200);
  endtask

  task automatic test_branch();
    Branch_i = 1'b1; zero_flag_i = 1'b1; PC_beq_i = 32'h0000_0040;
    #1;
    n_checks++;
    if (PCSrc_o !== 1'b1 || PC_beq_o !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL branch_taken: PCSrc=%b PC_beq=%h required 1 00000040", PCSrc_o, PC_beq_o);
    end
    zero_flag_i = 1'b0;
    #1;
    n_checks++;
    if (PCSrc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_not_taken: PCSrc=%b required 0", PCSrc_o);
    end
    zero_flag_i = 1'b1;
    // Same branch inputs held through a stalling load.
    run_mem_op("branch_load", 1'b0, 32'h0000_0180, 32'h0, 32'h0BAD_F00D, 1, 32'h0000_0180);
  endtask

  task automatic test_reset_mid_busy();
    MemRead_i = 1'b1; MemtoReg_i = 2'b01; RegWrite_i = 1'b1;
    alu_result_i = 32'h0000_0300; WriteRegister_i = 5'd4; inst_i = 32'h1111_2222;
    step();
    n_checks++;
    if (dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_entry: req=%b required 1", dmem_req);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, misalign_o, stall_o} !== '0 || wb_act !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: req=%b we=%b addr=%h stall=%b wb=%h required all 0",
               dmem_req, dmem_we, dmem_addr, stall_o, wb_act);
    end
    idle_inputs();
    step();
    step();
    reset = 1'b1;
    // Spurious ack alongside an ALU op right after release: must not leak data.
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_0000;
    test_alu_op(32'h0000_0077, 5'd3, 32'h0033_0033);
    n_checks++;
    if (dmem_req !== 1'b0 || ReadData_o !== 32'h0) begin
      n_fail++;
      $display("FAIL spurious_ack: req=%b ReadData=%h required 0 0", dmem_req, ReadData_o);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    MemRead_i = 1'b1; MemtoReg_i = 2'b01; RegWrite_i = 1'b1;
    alu_result_i = 32'h0000_0102; WriteRegister_i = 5'd6; inst_i = 32'h0000_0303;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_stall: stall=%b required 0", stall_o);
    end
    step();
    n_checks++;
    if (dmem_req !== 1'b0 || misalign_o !== 1'b1 || RegWrite_o !== 1'b0 || wb_act !== '0) begin
      n_fail++;
      $display("FAIL misalign_trap: req=%b mis=%b rw=%b wb=%h required 0 1 0 0",
               dmem_req, misalign_o, RegWrite_o, wb_act);
    end
    idle_inputs();
    step();
    n_checks++;
    if (misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_pulse: mis=%b required 0", misalign_o);
    end
`else
    run_mem_op("misalign_load", 1'b0, 32'h0000_0102, 32'h0, 32'hCAFE_0102, 0, 32'h0000_0100);
    n_checks++;
    if (misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_tied: mis=%b required 0", misalign_o);
    end
`endif
  endtask

  task automatic test_back_to_back();
    test_alu_op(32'h0000_0010, 5'd8, 32'h0100_0413);
    run_mem_op("b2b_load", 1'b0, 32'h0000_0104, 32'h0, 32'h8765_4321, 2, 32'h0000_0104);
    run_mem_op("b2b_store", 1'b1, 32'h0000_0208, 32'hA5A5_5A5A, 32'h0, 1, 32'h0000_0208);
    test_alu_op(32'hFFFF_FFF0, 5'd31, 32'hFFFF_0FF3);
  endtask

  initial begin
    test_reset();
    test_alu_op(32'h0000_0010, 5'd8, 32'h0100_0413);
    test_load();
    test_store();
    test_branch();
    test_reset_mid_busy();
    test_misalign();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
